// File: rtl/aud_adc_receiver.sv
// WM8731 I2S ADC receiver: captures left-channel samples from the codec pins
// and issues one SRAM write strobe per sample at an incrementing word address.
module aud_adc_receiver #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_AUD_BCLK,
  input  logic              i_AUD_ADCLRCK,
  input  logic              i_AUD_ADCDAT,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_wr,
  output logic [ADDR_W:0]   o_len,
  output logic              o_full,
  output logic [2:0]        o_state
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_SKIP  = 3'd2,
    S_SHIFT = 3'd3,
    S_WRITE = 3'd4,
    S_PAUSE = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   bclk_prev_q, bclk_prev_d;
  logic                   lrck_prev_q, lrck_prev_d;
  logic [DATA_W-1:0]      sr_q, sr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [ADDR_W:0]        len_q, len_d;
  logic                   full_q, full_d;
  logic                   pend_q, pend_d;

  logic bclk_s, lrck_s, dat_s;
  logic bclk_rise, lrck_fall;

  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
  assign dat_s     = dat_sync_q[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_prev_q;
  assign lrck_fall = ~lrck_s & lrck_prev_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      dat_sync_q  <= '0;
      bclk_prev_q <= 1'b0;
      lrck_prev_q <= 1'b0;
      sr_q        <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      full_q      <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bclk_sync_q <= bclk_sync_d;
      lrck_sync_q <= lrck_sync_d;
      dat_sync_q  <= dat_sync_d;
      bclk_prev_q <= bclk_prev_d;
      lrck_prev_q <= lrck_prev_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      full_q      <= full_d;
      pend_q      <= pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], i_AUD_BCLK};
    lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], i_AUD_ADCLRCK};
    dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], i_AUD_ADCDAT};
    bclk_prev_d = bclk_s;
    lrck_prev_d = lrck_s;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    len_d       = len_q;
    full_d      = full_q;
    pend_d      = pend_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d  = '0;
          len_d   = '0;
          full_d  = 1'b0;
          pend_d  = 1'b0;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (i_stop) begin
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (i_pause) pend_d = 1'b1;
          if (lrck_fall) state_d = S_SKIP;
        end
      end
      // I2S places the MSB one bit clock after the frame edge.
      S_SKIP: begin
        if (i_stop) begin
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (i_pause) pend_d = 1'b1;
          if (bclk_rise) begin
            cnt_d   = '0;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        if (i_stop) begin
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (i_pause) pend_d = 1'b1;
          if (bclk_rise) begin
            sr_d  = {sr_q[DATA_W-2:0], dat_s};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_WRITE;
          end
        end
      end
      // The strobe has already gone out this cycle, so the word is counted
      // even if a stop arrives alongside it.
      S_WRITE: begin
        addr_d = addr_q + 1'b1;
        len_d  = len_q + 1'b1;
        pend_d = 1'b0;
        if (addr_q == {ADDR_W{1'b1}}) begin
          full_d  = 1'b1;
          state_d = S_IDLE;
        end else if (i_stop) begin
          state_d = S_IDLE;
        end else if (pend_q) begin
          state_d = S_PAUSE;
        end else begin
          state_d = S_ARM;
        end
      end
      S_PAUSE: begin
        if (i_stop) state_d = S_IDLE;
        else if (i_start) state_d = S_ARM;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_wr    = (state_q == S_WRITE);
    o_data  = sr_q;
    o_addr  = addr_q;
    o_len   = len_q;
    o_full  = full_q;
    o_state = state_q;
  end

endmodule

// File: tb/tb_aud_adc_receiver.sv
// Directed bench for aud_adc_receiver: I2S frames in, expected SRAM writes
// queued by the stimulus and checked by an independent write monitor.
module tb_aud_adc_receiver;

  localparam int DW = 16;
  localparam int AW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst, start, pause, stop;
  logic          bclk, lrck, dat;
  logic [DW-1:0] o_data;
  logic [AW-1:0] o_addr;
  logic          o_wr;
  logic [AW:0]   o_len;
  logic          o_full;
  logic [2:0]    o_state;

  wr_t exp_q[$];
  int  nvec = 0;
  int  nerr = 0;

  always #5 clk = ~clk;

  aud_adc_receiver #(.DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
    .i_AUD_BCLK(bclk), .i_AUD_ADCLRCK(lrck), .i_AUD_ADCDAT(dat),
    .o_data(o_data), .o_addr(o_addr), .o_wr(o_wr), .o_len(o_len),
    .o_full(o_full), .o_state(o_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst && o_wr) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_write: got data=0x%0h addr=%0d, expected no write", o_data, o_addr);
        end else begin
          e = exp_q.pop_front();
          if (o_data !== e.data || o_addr !== e.addr) begin
            nerr++;
            $display("FAIL write: got data=0x%0h addr=%0d, expected data=0x%0h addr=%0d",
                     o_data, o_addr, e.data, e.addr);
          end
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic p, input logic t);
    start = s; pause = p; stop = t;
    cyc();
    start = 1'b0; pause = 1'b0; stop = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [AW-1:0] a);
    wr_t e;
    e.data = d;
    e.addr = a;
    exp_q.push_back(e);
  endtask

  // One I2S frame at BCLK = clk/6: a junk delay bit then 16 data bits per channel.
  // act_kind: 0 none, 1 pause, 2 stop, 3 stop+pause, 4 reset, applied once
  // left bit index act_bit has been clocked in.
  task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                       input int act_bit, input int act_kind);
    logic [DW:0] word;
    for (int ch = 0; ch < 2; ch++) begin
      word = (ch == 0) ? {~l[DW-1], l} : {~r[DW-1], r};
      for (int s = 0; s <= DW; s++) begin
        bclk = 1'b0;
        if (s == 0) lrck = (ch == 1);
        dat = word[DW-s];
        repeat (3) cyc();
        bclk = 1'b1;
        repeat (3) cyc();
        if (ch == 0 && s == act_bit + 1) begin
          case (act_kind)
            1: begin pulse(1'b0, 1'b1, 1'b0); chk("pause_defers", 32'(o_state), 32'd3); end
            2: begin pulse(1'b0, 1'b0, 1'b1); chk("stop_state", 32'(o_state), 32'd0); end
            3: begin pulse(1'b0, 1'b1, 1'b1); chk("stop_beats_pause", 32'(o_state), 32'd0); end
            4: begin
              #1 rst = 1'b1;
              #1;
              chk("rst_state", 32'(o_state), 32'd0);
              chk("rst_wr", 32'(o_wr), 32'd0);
              chk("rst_data", 32'(o_data), 32'd0);
              chk("rst_addr", 32'(o_addr), 32'd0);
              chk("rst_len", 32'(o_len), 32'd0);
              chk("rst_full", 32'(o_full), 32'd0);
              cyc();
              rst = 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  endtask

  initial begin
    logic [DW-1:0] w;
    logic [DW-1:0] words [3];
    words[0] = 16'h0001; words[1] = 16'h8000; words[2] = 16'h7FFF;
    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
    bclk = 1'b0; lrck = 1'b1; dat = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("reset_state", 32'(o_state), 32'd0);
    chk("reset_wr", 32'(o_wr), 32'd0);
    chk("reset_addr", 32'(o_addr), 32'd0);
    chk("reset_len", 32'(o_len), 32'd0);
    chk("reset_full", 32'(o_full), 32'd0);
    chk("reset_data", 32'(o_data), 32'd0);

    // Single sample
    pulse(1'b1, 1'b0, 1'b0);
    chk("start_arm", 32'(o_state), 32'd1);
    push(16'hA5C3, 3'd0);
    frame(16'hA5C3, 16'hFFFF, -1, 0);
    chk("single_pending", 32'(exp_q.size()), 32'd0);
    chk("single_addr", 32'(o_addr), 32'd1);
    chk("single_len", 32'(o_len), 32'd1);
    chk("single_state", 32'(o_state), 32'd1);

    // Multi-frame stream from a fresh start
    pulse(1'b0, 1'b0, 1'b1);
    chk("idle_stop", 32'(o_state), 32'd0);
    chk("idle_len_kept", 32'(o_len), 32'd1);
    pulse(1'b1, 1'b0, 1'b0);
    chk("restart_len", 32'(o_len), 32'd0);
    chk("restart_addr", 32'(o_addr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      push(words[i], AW'(i));
      frame(words[i], 16'hFFFF, -1, 0);
      chk("multi_pending", 32'(exp_q.size()), 32'd0);
      chk("multi_state", 32'(o_state), 32'd1);
      chk("multi_addr", 32'(o_addr), 32'(i + 1));
    end

    // Stop mid-word
    frame(16'h5A5A, 16'h0000, 9, 2);
    chk("stop_len_kept", 32'(o_len), 32'd3);
    chk("stop_pending", 32'(exp_q.size()), 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("stop_restart_len", 32'(o_len), 32'd0);
    chk("stop_restart_addr", 32'(o_addr), 32'd0);

    // Pause mid-word, two idle frames, then resume
    push(16'hC0DE, 3'd0);
    frame(16'hC0DE, 16'h1234, 4, 1);
    chk("pause_state", 32'(o_state), 32'd5);
    chk("pause_addr", 32'(o_addr), 32'd1);
    repeat (2) frame(16'hBEEF, 16'hBEEF, -1, 0);
    chk("paused_state", 32'(o_state), 32'd5);
    chk("paused_len", 32'(o_len), 32'd1);
    pulse(1'b1, 1'b0, 1'b0);
    chk("resume_state", 32'(o_state), 32'd1);
    push(16'h2468, 3'd1);
    frame(16'h2468, 16'h0000, -1, 0);
    chk("resume_pending", 32'(exp_q.size()), 32'd0);
    chk("resume_addr", 32'(o_addr), 32'd2);
    chk("resume_len", 32'(o_len), 32'd2);

    // Asynchronous reset during SHIFT
    frame(16'hFFFF, 16'h0000, 6, 4);
    chk("post_rst_state", 32'(o_state), 32'd0);

    // Fill the 8-word address space, ninth frame must be dropped
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      w = 16'h1000 + 16'(i) * 16'h0111;
      if (i < 8) push(w, AW'(i));
      frame(w, ~w, -1, 0);
      if (i == 7) begin
        chk("full_flag", 32'(o_full), 32'd1);
        chk("full_state", 32'(o_state), 32'd0);
        chk("full_len", 32'(o_len), 32'd8);
        chk("full_addr_wrap", 32'(o_addr), 32'd0);
      end
    end
    chk("full_pending", 32'(exp_q.size()), 32'd0);
    chk("full_ninth_state", 32'(o_state), 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("full_cleared", 32'(o_full), 32'd0);
    chk("full_restart_state", 32'(o_state), 32'd1);

    // Stop and pause together
    frame(16'h3C3C, 16'h0000, 3, 3);
    chk("sim_len", 32'(o_len), 32'd0);
    chk("sim_pending", 32'(exp_q.size()), 32'd0);

    repeat (10) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
